// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_seq_pkg : shared types and width helpers for the PWM slots    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pwm_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_POPCNT = 1'b0;
    localparam logic MODE_BIN    = 1'b1;

    // Counter/duty width must hold the value PERIOD itself (fully active slot).
    function automatic int cnt_width(input int period);
        return $clog2(period + 1);
    endfunction

    function automatic int slot_width(input int n_slots);
        return (n_slots > 1) ? $clog2(n_slots) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_duty_decode : switch group -> clamped duty (popcount/binary)  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pwm_duty_decode
    import pwm_seq_pkg::*;
#(
    parameter int SW_W   = 4,
    parameter int PERIOD = 4,
    parameter int CNT_W  = cnt_width(PERIOD)
) (
    input  logic [SW_W-1:0]  group,
    input  logic             mode,
    output logic [CNT_W-1:0] d_eff
);

    // Work wide enough that large binary codes clamp instead of wrapping.
    localparam int W = (SW_W > CNT_W) ? SW_W : CNT_W;

    logic [W-1:0] w_popcnt;
    logic [W-1:0] w_raw;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < SW_W; i++) begin
            w_popcnt = w_popcnt + W'(group[i]);
        end
    end

    assign w_raw = (mode == MODE_BIN) ? W'(group) : w_popcnt;
    assign d_eff = (w_raw > W'(PERIOD)) ? CNT_W'(PERIOD) : w_raw[CNT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/pwm_slot_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_slot_sequencer : N-slot serial PWM with graceful stop         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pwm_slot_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int SW_W    = 4,
    parameter int PERIOD  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              mode,
    input  logic                              inv,
    input  logic [N_SLOTS*SW_W-1:0]           sw,
    output logic                              out,
    output logic [slot_width(N_SLOTS)-1:0]    slot_idx,
    output logic                              frame_start,
    output logic                              busy
);

    localparam int CNT_W  = cnt_width(PERIOD);
    localparam int SLOT_W = slot_width(N_SLOTS);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
    logic [CNT_W-1:0]    r_duty_shadow;
    logic [CNT_W-1:0]    w_dec;
    logic [CNT_W-1:0]    w_duty;
    logic [SW_W-1:0]     w_group;
    logic                w_last_cnt;
    logic                w_last_slot;
    logic                w_out_nxt;
    logic                w_busy_nxt;
    logic                w_fs_nxt;
    logic [SLOT_W-1:0]   w_slot_idx_nxt;

    always_comb begin
        w_group = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (r_slot == SLOT_W'(s)) begin
                w_group = sw[s*SW_W +: SW_W];
            end
        end
    end

    pwm_duty_decode #(
        .SW_W   (SW_W),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_decode (
        .group (w_group),
        .mode  (mode),
        .d_eff (w_dec)
    );

    // Fresh decode on the first cycle of a slot, frozen copy for the rest.
    assign w_duty      = (r_cnt == '0) ? w_dec : r_duty_shadow;
    assign w_last_cnt  = (r_cnt == CNT_W'(PERIOD - 1));
    assign w_last_slot = (r_slot == SLOT_W'(N_SLOTS - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_slot_nxt     = r_slot;
        w_out_nxt      = inv;
        w_busy_nxt     = 1'b0;
        w_fs_nxt       = 1'b0;
        w_slot_idx_nxt = '0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_slot_nxt = '0;
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_out_nxt      = (r_cnt < w_duty) ^ inv;
                w_busy_nxt     = 1'b1;
                w_slot_idx_nxt = r_slot;
                w_fs_nxt       = (r_slot == '0) && (r_cnt == '0);
                if (w_last_cnt) begin
                    w_cnt_nxt = '0;
                    if (w_last_slot) begin
                        // en is only honoured at the frame boundary.
                        w_slot_nxt = '0;
                        if (!en) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_slot_nxt = r_slot + SLOT_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_slot        <= '0;
            r_duty_shadow <= '0;
            out           <= 1'b0;
            slot_idx      <= '0;
            frame_start   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_slot      <= w_slot_nxt;
            out         <= w_out_nxt;
            slot_idx    <= w_slot_idx_nxt;
            frame_start <= w_fs_nxt;
            busy        <= w_busy_nxt;
            if (r_state == RUN && r_cnt == '0) begin
                r_duty_shadow <= w_dec;
            end
        end
    end

endmodule
`default_nettype wire
